prj7620_i2c_slave: RTL

PRJ7620_I2C_SLAVE -- requirements
Module: prj7620_i2c_slave

---
 rtl/prj7620_i2c_slave.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/prj7620_i2c_slave.sv
// I2C register-write/read slave for the PRJ7620 register bank.
// Optional pointer auto-increment: define PRJ7620_AUTOINC_EN.
module prj7620_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h73
) (
  input  logic       i2c_clk,
  input  logic       sys_rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       bank_sel,
  output logic [5:0] wr_cnt
);

`ifdef PRJ7620_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV     = 4'd1;
  localparam logic [3:0] DEV_ACK = 4'd2;
  localparam logic [3:0] REG     = 4'd3;
  localparam logic [3:0] REG_ACK = 4'd4;
  localparam logic [3:0] WDATA   = 4'd5;
  localparam logic [3:0] WACK    = 4'd6;
  localparam logic [3:0] RDATA   = 4'd7;
  localparam logic [3:0] MACK    = 4'd8;
  localparam logic [3:0] IGNORE  = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_p;
  logic       sda_p;
  logic       scl_q;
  logic       sda_q;

  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic       ack_ph;
  logic       rd_load;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       ev_ok;
  logic [7:0] byte_nx;

  logic       shift_in;
  logic       byte_done;
  logic       wr_fire;
  logic       ack_fall;
  logic       ptr_load;
  logic       rd_start;
  logic       rd_shift;
  logic       rd_end;
  logic       rd_bit;
  logic       mack_ack;

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_p    <= scl_sync[1];
      sda_p    <= sda_sync[1];
    end
  end

  assign scl_q     = scl_sync[1];
  assign sda_q     = sda_sync[1];
  assign scl_rise  = scl_q & ~scl_p;
  assign scl_fall  = ~scl_q & scl_p;
  assign start_det = scl_q & scl_p & sda_p & ~sda_q;
  assign stop_det  = scl_q & scl_p & ~sda_p & sda_q;
  assign ev_ok     = ~start_det & ~stop_det;
  assign byte_nx   = {shift_q[6:0], sda_q};

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = DEV;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        DEV:
          if (byte_done)
            state_d = (byte_nx[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
        DEV_ACK:
          if (scl_fall & ack_ph)
            state_d = shift_q[0] ? RDATA : REG;
        REG:
          if (byte_done) state_d = REG_ACK;
        REG_ACK:
          if (scl_fall & ack_ph) state_d = WDATA;
        WDATA:
          if (byte_done) state_d = WACK;
        WACK:
          if (scl_fall & ack_ph) state_d = WDATA;
        RDATA:
          if (rd_end) state_d = MACK;
        MACK:
          if (scl_rise) state_d = sda_q ? IGNORE : RDATA;
        default: ;
      endcase
    end
  end

  // Per-cycle action strobes; START/STOP suppress every bit-level action.
  always_comb begin
    shift_in = 1'b0;
    ack_fall = 1'b0;
    ptr_load = 1'b0;
    rd_start = 1'b0;
    rd_shift = 1'b0;
    rd_end   = 1'b0;
    rd_bit   = 1'b0;
    mack_ack = 1'b0;
    if (ev_ok) begin
      unique case (state_q)
        DEV, REG, WDATA:
          shift_in = scl_rise;
        DEV_ACK: begin
          ack_fall = scl_fall;
          rd_start = scl_fall & ack_ph & shift_q[0];
        end
        REG_ACK: begin
          ack_fall = scl_fall;
          ptr_load = scl_fall & ack_ph;
        end
        WACK:
          ack_fall = scl_fall;
        RDATA: begin
          rd_start = scl_fall & rd_load;
          rd_shift = scl_fall & ~rd_load & (bit_cnt != 3'd0);
          rd_end   = scl_fall & ~rd_load & (bit_cnt == 3'd0);
          rd_bit   = scl_rise & ~rd_load;
        end
        MACK:
          mack_ack = scl_rise & ~sda_q;
        default: ;
      endcase
    end
  end

  assign byte_done = shift_in & (bit_cnt == 3'd7);
  assign wr_fire   = byte_done & (state_q == WDATA);

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sda_oe   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      rd_addr  <= 8'h00;
      bank_sel <= 1'b0;
      wr_cnt   <= 6'd0;
      shift_q  <= 8'h00;
      bit_cnt  <= 3'd0;
      ack_ph   <= 1'b0;
      rd_load  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (!ev_ok) begin
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        ack_ph  <= 1'b0;
        rd_load <= 1'b0;
      end else begin
        if (shift_in) begin
          shift_q <= byte_nx;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (rd_bit) bit_cnt <= bit_cnt + 3'd1;
        if (wr_fire) begin
          wr_en   <= 1'b1;
          wr_addr <= rd_addr;
          wr_data <= byte_nx;
          if (wr_cnt != 6'd63) wr_cnt <= wr_cnt + 6'd1;
          if (rd_addr == 8'hEF) bank_sel <= byte_nx[0];
          if (AUTOINC) rd_addr <= rd_addr + 8'd1;
        end
        // First falling edge of an ACK slot pulls SDA, the second releases it.
        if (ack_fall) begin
          ack_ph <= ~ack_ph;
          sda_oe <= ~ack_ph;
        end
        if (ptr_load) rd_addr <= shift_q;
        if (rd_start) begin
          shift_q <= rd_data;
          sda_oe  <= ~rd_data[7];
          rd_load <= 1'b0;
        end
        if (rd_shift) begin
          shift_q <= {shift_q[6:0], 1'b0};
          sda_oe  <= ~shift_q[6];
        end
        if (rd_end) sda_oe <= 1'b0;
        if (mack_ack) begin
          rd_load <= 1'b1;
          if (AUTOINC) rd_addr <= rd_addr + 8'd1;
        end
      end
    end
  end

endmodule
